// File: rtl/msg_frame_ctrl.sv
// msg_frame_ctrl: framed-message serializer for the HSI master transmit path.
// Emits MARKER, FLAG, LEN_HI, LEN_LO, payload (MSB byte first) and an optional
// XOR checksum over a registered valid/ack byte handshake. A one-deep pending
// buffer lets the next payload be loaded while a frame is in flight.
module msg_frame_ctrl #(
  parameter int         PL_BYTES = 5,
  parameter logic [7:0] MARKER   = 8'hAA,
  parameter logic [7:0] FLAG     = 8'h0B,
  parameter bit         CKS_EN   = 1'b0
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  load,
  input  logic [PL_BYTES*8-1:0] payload,
  input  logic                  tx_en,
  input  logic                  q_ack,
  output logic [7:0]            q,
  output logic                  q_vld,
  output logic                  msg_end,
  output logic                  busy,
  output logic                  ovr
);

  localparam int PW = PL_BYTES * 8;
  // The index must cover both the 4 header bytes and the payload bytes.
  localparam int CW = $clog2(PL_BYTES + 1);
  localparam int IW = (CW > 2) ? CW : 2;

  localparam logic [IW-1:0] HDR_LAST = IW'(3);
  localparam logic [IW-1:0] PL_LAST  = IW'(PL_BYTES - 1);
  localparam logic [7:0]    LEN_LO   = 8'(PL_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PL,
    CKS,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [7:0]      cks, cks_nxt;
  logic [PW-1:0]   tx_reg, tx_nxt;
  logic [PW-1:0]   pend_reg;
  logic            pend;
  logic            start;
  logic            accept;
  logic [PW-1:0]   pl_shift;
  logic [7:0]      q_nxt;
  logic            q_vld_nxt;
  logic            msg_end_nxt;

  assign accept = q_vld & q_ack;
  assign busy   = (state != IDLE);

  // State register plus frame datapath; q/q_vld/msg_end are registered copies
  // of what the next state will present, so they line up with the state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      idx     <= '0;
      cks     <= '0;
      tx_reg  <= '0;
      q       <= '0;
      q_vld   <= 1'b0;
      msg_end <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cks     <= cks_nxt;
      tx_reg  <= tx_nxt;
      q       <= q_nxt;
      q_vld   <= q_vld_nxt;
      msg_end <= msg_end_nxt;
    end
  end

  // Pending buffer: newest load always wins; overrun only when unsent data is lost.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend     <= 1'b0;
      pend_reg <= '0;
      ovr      <= 1'b0;
    end else begin
      ovr <= load & pend & ~start;
      if (load) begin
        pend_reg <= payload;
        pend     <= 1'b1;
      end else if (start) begin
        pend     <= 1'b0;
      end
    end
  end

  // Next-state logic: advance only on accepted bytes, abort whenever tx_en drops.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cks_nxt   = cks;
    tx_nxt    = tx_reg;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (tx_en && pend) start = 1'b1;
      end
      HDR: begin
        if (!tx_en) begin
          state_nxt = IDLE;
        end else if (accept) begin
          if (idx == HDR_LAST) begin
            state_nxt = PL;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      PL: begin
        if (!tx_en) begin
          state_nxt = IDLE;
        end else if (accept) begin
          cks_nxt = cks ^ q;
          if (idx == PL_LAST) begin
            state_nxt = CKS_EN ? CKS : DONE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      CKS: begin
        if (!tx_en) begin
          state_nxt = IDLE;
        end else if (accept) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (tx_en && pend) begin
          start = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (start) begin
      state_nxt = HDR;
      idx_nxt   = '0;
      cks_nxt   = '0;
      tx_nxt    = pend_reg;
    end
  end

  // Output logic: select the byte the next state will present.
  always_comb begin
    q_nxt       = '0;
    q_vld_nxt   = 1'b0;
    msg_end_nxt = 1'b0;
    pl_shift    = tx_nxt << {idx_nxt, 3'b000};
    case (state_nxt)
      HDR: begin
        q_vld_nxt = 1'b1;
        case (idx_nxt)
          IW'(0):  q_nxt = MARKER;
          IW'(1):  q_nxt = FLAG;
          IW'(2):  q_nxt = 8'h00;
          default: q_nxt = LEN_LO;
        endcase
      end
      PL: begin
        q_vld_nxt = 1'b1;
        q_nxt     = pl_shift[PW-1 -: 8];
      end
      CKS: begin
        q_vld_nxt = 1'b1;
        q_nxt     = cks_nxt;
      end
      DONE: begin
        msg_end_nxt = 1'b1;
      end
      default: begin
        q_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_msg_frame_ctrl.sv
// tb_msg_frame_ctrl: directed self-checking bench for msg_frame_ctrl.
// One instance without checksum and one with checksum share load/payload/q_ack.
module tb_msg_frame_ctrl;

  localparam int PLB = 5;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             load;
  logic [PLB*8-1:0] payload;
  logic             tx_en;
  logic             tx_en_c;
  logic             q_ack;

  logic [7:0] q, q_c;
  logic       q_vld, q_vld_c;
  logic       msg_end, msg_end_c;
  logic       busy, busy_c;
  logic       ovr, ovr_c;

  int total = 0;
  int bad   = 0;

  logic [127:0] frameAcc;
  int           frameLen;
  int           gapCycles;
  int           holdErrs;
  int           msgEndSeen;

  msg_frame_ctrl #(.PL_BYTES(PLB), .CKS_EN(1'b0)) dut (
    .clk(clk), .n_rst(n_rst), .load(load), .payload(payload), .tx_en(tx_en),
    .q_ack(q_ack), .q(q), .q_vld(q_vld), .msg_end(msg_end), .busy(busy), .ovr(ovr)
  );

  msg_frame_ctrl #(.PL_BYTES(PLB), .CKS_EN(1'b1)) dut_c (
    .clk(clk), .n_rst(n_rst), .load(load), .payload(payload), .tx_en(tx_en_c),
    .q_ack(q_ack), .q(q_c), .q_vld(q_vld_c), .msg_end(msg_end_c), .busy(busy_c), .ovr(ovr_c)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle load pulse carrying the given payload.
  task automatic applyStimulus(input logic [PLB*8-1:0] data);
    payload = data;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  // Collect accepted bytes until msg_end (bounded), checking hold-under-stall.
  task automatic collectFrame(input bit useC, input logic [3:0] ackPat);
    logic [7:0] prevQ;
    logic [7:0] qs;
    logic       vs;
    logic       es;
    bit         prevStall;
    int         lastAcc;
    frameAcc   = '0;
    frameLen   = 0;
    gapCycles  = -1;
    holdErrs   = 0;
    msgEndSeen = 0;
    prevStall  = 1'b0;
    prevQ      = '0;
    lastAcc    = -100;
    for (int k = 0; k < 80; k++) begin
      qs    = useC ? q_c : q;
      vs    = useC ? q_vld_c : q_vld;
      es    = useC ? msg_end_c : msg_end;
      q_ack = ackPat[k % 4];
      if (prevStall && (!vs || qs !== prevQ)) holdErrs++;
      if (es) begin
        msgEndSeen = 1;
        gapCycles  = k - lastAcc;
        break;
      end
      if (vs && q_ack) begin
        frameAcc = {frameAcc[119:0], qs};
        frameLen++;
        lastAcc  = k;
      end
      prevStall = vs && !q_ack;
      prevQ     = qs;
      step();
    end
    q_ack = 1'b1;
  endtask

  initial begin
    int accepts;
    int cnt;
    n_rst   = 1'b0;
    load    = 1'b0;
    tx_en   = 1'b0;
    tx_en_c = 1'b0;
    q_ack   = 1'b0;
    payload = '0;

    // Reset state
    step();
    step();
    checkOutput("rst q", q, 0);
    checkOutput("rst q_vld", q_vld, 0);
    checkOutput("rst msg_end", msg_end, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst ovr", ovr, 0);
    checkOutput("rst busy_c", busy_c, 0);
    checkOutput("rst ovr_c", ovr_c, 0);
    n_rst = 1'b1;
    step();

    // Basic frame, q_ack held high
    applyStimulus(40'h0102030405);
    tx_en = 1'b1;
    q_ack = 1'b1;
    collectFrame(1'b0, 4'b1111);
    checkOutput("basic bytes", frameAcc, 128'hAA0B00050102030405);
    checkOutput("basic len", frameLen, 9);
    checkOutput("basic msg_end", msgEndSeen, 1);
    checkOutput("basic gap", gapCycles, 1);
    checkOutput("basic done q_vld", q_vld, 0);
    checkOutput("basic done busy", busy, 1);
    step();
    checkOutput("basic msg_end 1cyc", msg_end, 0);
    checkOutput("basic busy idle", busy, 0);

    // Backpressure with q_ack 1,0,0,1
    applyStimulus(40'h0102030405);
    collectFrame(1'b0, 4'b1001);
    checkOutput("bp bytes", frameAcc, 128'hAA0B00050102030405);
    checkOutput("bp len", frameLen, 9);
    checkOutput("bp hold", holdErrs, 0);
    checkOutput("bp msg_end", msgEndSeen, 1);

    // Checksum instance; the plain instance then drains the same payload
    tx_en = 1'b0;
    applyStimulus(40'h0102030405);
    tx_en_c = 1'b1;
    collectFrame(1'b1, 4'b1111);
    checkOutput("cks bytes", frameAcc, 128'hAA0B0005010203040501);
    checkOutput("cks len", frameLen, 10);
    checkOutput("cks gap", gapCycles, 1);
    checkOutput("cks msg_end", msgEndSeen, 1);
    tx_en_c = 1'b0;
    tx_en   = 1'b1;
    collectFrame(1'b0, 4'b1111);
    checkOutput("drain bytes", frameAcc, 128'hAA0B00050102030405);

    // Pending overwrite while disabled
    tx_en = 1'b0;
    step();
    applyStimulus(40'h1112131415);
    checkOutput("ovr first load", ovr, 0);
    applyStimulus(40'h2122232425);
    checkOutput("ovr pulse", ovr, 1);
    step();
    checkOutput("ovr one cycle", ovr, 0);
    checkOutput("ovr idle q_vld", q_vld, 0);
    tx_en = 1'b1;
    collectFrame(1'b0, 4'b1111);
    checkOutput("ovr bytes", frameAcc, 128'hAA0B00052122232425);
    checkOutput("ovr len", frameLen, 9);

    // Load during a frame: back-to-back frames with a one-cycle gap
    applyStimulus(40'h3132333435);
    step();
    step();
    step();
    applyStimulus(40'h5152535455);
    checkOutput("ovr mid frame", ovr, 0);
    collectFrame(1'b0, 4'b1111);
    checkOutput("b2b first end", msgEndSeen, 1);
    step();
    checkOutput("b2b restart vld", q_vld, 1);
    checkOutput("b2b restart AA", q, 8'hAA);
    collectFrame(1'b0, 4'b1111);
    checkOutput("b2b second bytes", frameAcc, 128'hAA0B00055152535455);

    // Load coinciding with frame start, then abort after the 6th byte
    step();
    applyStimulus(40'h4142434445);
    applyStimulus(40'h6162636465);
    checkOutput("ovr at start", ovr, 0);
    checkOutput("abort start AA", q, 8'hAA);
    accepts = 0;
    for (int k = 0; k < 20; k++) begin
      if (q_vld && q_ack) accepts++;
      step();
      if (accepts == 6) break;
    end
    checkOutput("abort accepts", accepts, 6);
    checkOutput("abort in PL byte", q, 8'h43);
    tx_en = 1'b0;
    step();
    checkOutput("abort q_vld", q_vld, 0);
    checkOutput("abort busy", busy, 0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (msg_end) cnt++;
      step();
    end
    checkOutput("abort no msg_end", cnt, 0);
    tx_en = 1'b1;
    collectFrame(1'b0, 4'b1111);
    checkOutput("abort restart bytes", frameAcc, 128'hAA0B00056162636465);

    // Asynchronous reset in the middle of the payload
    applyStimulus(40'h7172737475);
    step();
    step();
    step();
    step();
    step();
    checkOutput("pre-reset PL byte", q, 8'h71);
    n_rst = 1'b0;
    #1;
    checkOutput("async rst q", q, 0);
    checkOutput("async rst q_vld", q_vld, 0);
    checkOutput("async rst msg_end", msg_end, 0);
    checkOutput("async rst busy", busy, 0);
    checkOutput("async rst ovr", ovr, 0);
    step();
    n_rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (q_vld) cnt++;
      step();
    end
    checkOutput("post-rst no frame", cnt, 0);
    checkOutput("post-rst busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
